ddr_port_arbiter: RTL

Shares the CPU-side command port of `ddr_controller` between `N_REQ` requesters and sequences periodic auto-refresh. It sits between the system masters and `ddr_controller`. It does the following:
- arbitrates requesters round-robin;
- issues exactly one single-cycle command per transaction on `icmd`;
- steers write data and read data beats to and from the granted requester;
- holds off new commands while the controller reports `busy`.

---
 rtl/ddr_ctrl_pkg.sv | 42 ++++
 rtl/ddr_refresh_timer.sv | 41 ++++
 rtl/ddr_port_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_ctrl_pkg.sv
// Shared definitions for the ddr_controller front-end: command encodings,
// arbiter state enum and the round-robin pick helper.
package ddr_ctrl_pkg;

  localparam logic [2:0] C_READ    = 3'b000;
  localparam logic [2:0] C_WRITE   = 3'b001;
  localparam logic [2:0] C_REFRESH = 3'b010;
  localparam logic [2:0] C_NOP     = 3'b100;

  // Widest requester vector rr_pick handles; callers zero-extend narrower ones.
  localparam int unsigned MaxReq = 8;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StSettle,
    StData,
    StDrain,
    StRef
  } arb_state_e;

  // Next one-hot grant: first set request bit searching upward from last+1,
  // wrapping modulo n_req. Returns all zeros when nothing is requested.
  function automatic logic [MaxReq-1:0] rr_pick(input logic [MaxReq-1:0] req,
                                                input logic [2:0]        last,
                                                input int unsigned       n_req);
    logic [MaxReq-1:0] gnt;
    logic [2:0]        idx;
    logic              found;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MaxReq; i++) begin
      idx = 3'((32'(last) + i) % n_req);
      if ((i <= n_req) && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/ddr_refresh_timer.sv
// Auto-refresh interval timer: free-running down-counter that raises a
// sticky refresh request every REF_INTERVAL cycles until acknowledged.
module ddr_refresh_timer #(
  parameter int unsigned REF_INTERVAL = 780
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ref_ack,
  output logic ref_pending
);

  localparam int unsigned     CntW   = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [CntW-1:0] Reload = CntW'(REF_INTERVAL - 1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic            r_pending;
  logic            w_pending_d;
  logic            w_expire;

  // Count down, reload on zero; an expiry while pending simply keeps it set
  always_comb begin
    w_expire    = (r_cnt == '0);
    w_cnt_d     = w_expire ? Reload : (r_cnt - CntW'(1));
    w_pending_d = w_expire | (r_pending & ~ref_ack);
  end

  // Counter and pending flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= Reload;
      r_pending <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_d;
      r_pending <= w_pending_d;
    end
  end

  assign ref_pending = r_pending;

endmodule

// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing ddr_controller's command port among N_REQ
// masters, steering burst data to/from the granted master and slotting in
// periodic auto-refresh between transactions.
module ddr_port_arbiter
  import ddr_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned BURST_LEN    = 4,
  parameter int unsigned REF_INTERVAL = 780
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     m_req,
  input  logic [N_REQ-1:0]     m_we,
  input  logic [N_REQ*32-1:0]  m_addr,
  input  logic [N_REQ*32-1:0]  m_wdata,
  input  logic [N_REQ*4-1:0]   m_dmsel,
  output logic [N_REQ-1:0]     m_gnt,
  output logic [N_REQ-1:0]     m_wack,
  output logic [N_REQ-1:0]     m_rvalid,
  output logic [31:0]          m_rdata,
  output logic [N_REQ-1:0]     m_done,
  output logic [2:0]           icmd,
  output logic [31:0]          iaddr,
  output logic [31:0]          data_in,
  output logic [3:0]           dmsel,
  input  logic                 busy,
  input  logic [31:0]          dataout,
  input  logic                 dataout_valid,
  input  logic                 datain_valid
);

  localparam int unsigned      BeatW    = $clog2(BURST_LEN + 1);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_LEN - 1);

  arb_state_e       r_state, w_state_d;
  logic [2:0]       r_icmd, w_icmd_d;
  logic [31:0]      r_iaddr, w_iaddr_d;
  logic [3:0]       r_dmsel, w_dmsel_d;
  logic [N_REQ-1:0] r_gnt, w_gnt_d;
  logic [N_REQ-1:0] r_done, w_done_d;
  logic [2:0]       r_last, w_last_d;
  logic             r_dir, w_dir_d;
  logic [BeatW-1:0] r_beat, w_beat_d;
  logic [1:0]       r_ref_step, w_ref_step_d;

  logic              w_ref_pending;
  logic              w_ref_ack;
  logic [MaxReq-1:0] w_req_ext;
  logic [MaxReq-1:0] w_pick;
  logic              w_pick_any;
  logic [2:0]        w_pick_idx;
  logic [31:0]       w_pick_addr;
  logic              w_pick_we;
  logic [3:0]        w_pick_dmsel;
  logic [31:0]       w_gnt_wdata;
  logic              w_in_data;
  logic              w_wr_beat;
  logic              w_rd_beat;
  logic              w_last_beat;

  ddr_refresh_timer #(
    .REF_INTERVAL(REF_INTERVAL)
  ) u_ref_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .ref_ack    (w_ref_ack),
    .ref_pending(w_ref_pending)
  );

  // Round-robin winner. The requester currently seeing m_done still holds
  // m_req this cycle, so it is masked to avoid an unwanted re-grant.
  always_comb begin
    w_req_ext              = '0;
    w_req_ext[N_REQ-1:0]   = m_req & ~r_done;
    w_pick                 = rr_pick(w_req_ext, r_last, N_REQ);
    w_pick_any             = |w_pick;
    w_pick_idx             = '0;
    w_pick_addr            = '0;
    w_pick_we              = 1'b0;
    w_pick_dmsel           = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_pick[i]) begin
        w_pick_idx   = 3'(i);
        w_pick_addr  = m_addr[32*i +: 32];
        w_pick_we    = m_we[i];
        w_pick_dmsel = m_dmsel[4*i +: 4];
      end
    end
  end

  // Write data mux from the granted requester; zero when nothing is granted
  always_comb begin
    w_gnt_wdata = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (r_gnt[i]) w_gnt_wdata = m_wdata[32*i +: 32];
    end
  end

  // Beat strobes: only in DATA and only for the transaction's direction
  always_comb begin
    w_in_data   = (r_state == StData);
    w_wr_beat   = w_in_data & r_dir & datain_valid;
    w_rd_beat   = w_in_data & ~r_dir & dataout_valid;
    w_last_beat = (w_wr_beat | w_rd_beat) & (r_beat == LastBeat);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_icmd     <= C_NOP;
      r_iaddr    <= '0;
      r_dmsel    <= '0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_last     <= 3'(N_REQ - 1);
      r_dir      <= 1'b0;
      r_beat     <= '0;
      r_ref_step <= '0;
    end else begin
      r_state    <= w_state_d;
      r_icmd     <= w_icmd_d;
      r_iaddr    <= w_iaddr_d;
      r_dmsel    <= w_dmsel_d;
      r_gnt      <= w_gnt_d;
      r_done     <= w_done_d;
      r_last     <= w_last_d;
      r_dir      <= w_dir_d;
      r_beat     <= w_beat_d;
      r_ref_step <= w_ref_step_d;
    end
  end

  // Next-state: refresh wins in IDLE; transactions always run to completion
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (!busy) begin
          if (w_ref_pending)   w_state_d = StRef;
          else if (w_pick_any) w_state_d = StIssue;
        end
      end
      StIssue:  w_state_d = StSettle;
      StSettle: w_state_d = StData;
      StData: begin
        if (w_last_beat) w_state_d = StDrain;
      end
      StDrain: begin
        if (!busy) w_state_d = StIdle;
      end
      StRef: begin
        if ((r_ref_step == 2'd2) && !busy) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Next values of registered outputs; icmd is loaded on the transition so
  // it is valid for exactly the cycle spent in ISSUE (or the first REF cycle)
  always_comb begin
    w_icmd_d     = C_NOP;
    w_iaddr_d    = r_iaddr;
    w_dmsel_d    = r_dmsel;
    w_gnt_d      = r_gnt;
    w_done_d     = '0;
    w_last_d     = r_last;
    w_dir_d      = r_dir;
    w_beat_d     = r_beat;
    w_ref_step_d = r_ref_step;
    w_ref_ack    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!busy) begin
          if (w_ref_pending) begin
            w_icmd_d     = C_REFRESH;
            w_ref_step_d = 2'd0;
          end else if (w_pick_any) begin
            w_gnt_d   = w_pick[N_REQ-1:0];
            w_last_d  = w_pick_idx;
            w_iaddr_d = w_pick_addr;
            w_dir_d   = w_pick_we;
            w_dmsel_d = w_pick_dmsel;
            w_icmd_d  = w_pick_we ? C_WRITE : C_READ;
          end
        end
      end
      StData: begin
        if (w_wr_beat | w_rd_beat) w_beat_d = r_beat + BeatW'(1);
      end
      StDrain: begin
        if (!busy) begin
          w_done_d = r_gnt;
          w_gnt_d  = '0;
          w_beat_d = '0;
        end
      end
      StRef: begin
        // Step 0 = REFRESH cycle, step 1 = NOP cycle, step 2 = wait for idle
        if (r_ref_step != 2'd2) begin
          w_ref_step_d = r_ref_step + 2'd1;
        end else if (!busy) begin
          w_ref_ack = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign icmd     = r_icmd;
  assign iaddr    = r_iaddr;
  assign dmsel    = r_dmsel;
  assign m_gnt    = r_gnt;
  assign m_done   = r_done;
  assign data_in  = w_gnt_wdata;
  assign m_wack   = w_wr_beat ? r_gnt : '0;
  assign m_rvalid = w_rd_beat ? r_gnt : '0;
  assign m_rdata  = dataout;

endmodule
